mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating instruction fetches and data loads/stores.
// Optional IO_STALL_EN: stores into the IO region (>= 0x30000) hold while io_buffer_full is set.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_mem,
  input  logic        if_req,
  output logic        addr_needed,
  output logic        inst_available,
  output logic [31:0] inst_in,
  output logic [31:0] pc_back,
  input  logic        branch_interception,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [1:0]  memcnf,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  input  logic        io_buffer_full
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] len, len_d;
  logic [AW-1:0] base, base_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] din_lane;
  logic [BW-1:0] wr_byte;
  logic          io_stall;

  function automatic logic [CW-1:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    return CW'(1);
      2'd1:    return CW'(2);
      default: return CW'(4);
    endcase
  endfunction

`ifdef IO_STALL_EN
  localparam logic [AW-1:0] IO_BASE = AW'(32'h0003_0000);
  // Only the first byte of an IO store waits; once started the store runs to completion.
  assign io_stall = (state == ST_STORE) && (cnt == '0) && (base >= IO_BASE) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // ram_din carries byte (cnt-1) of the current read; place it in its little-endian lane.
  always_comb begin
    din_lane = '0;
    case (cnt)
      CW'(1):  din_lane = {24'h0, ram_din};
      CW'(2):  din_lane = {16'h0, ram_din, 8'h0};
      CW'(3):  din_lane = {8'h0, ram_din, 16'h0};
      CW'(4):  din_lane = {ram_din, 24'h0};
      default: din_lane = '0;
    endcase
  end

  always_comb begin
    wr_byte = '0;
    case (cnt[1:0])
      2'd0:    wr_byte = acc_q[7:0];
      2'd1:    wr_byte = acc_q[15:8];
      2'd2:    wr_byte = acc_q[23:16];
      default: wr_byte = acc_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len   <= '0;
      base  <= '0;
      acc_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      len   <= len_d;
      base  <= base_d;
      acc_q <= acc_d;
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    len_d          = len;
    base_d         = base;
    acc_d          = acc_q;
    addr_needed    = 1'b0;
    inst_available = 1'b0;
    inst_in        = '0;
    pc_back        = '0;
    mem_done       = 1'b0;
    mem_rdata      = '0;
    ram_addr       = '0;
    ram_dout       = '0;
    ram_wr         = 1'b0;

    case (state)
      ST_IDLE: begin
        addr_needed = !mem_req;
        // Data accesses win over fetches; a branch blocks fetch acceptance this cycle.
        if (mem_req) begin
          state_d = mem_we ? ST_STORE : ST_LOAD;
          cnt_d   = '0;
          len_d   = size_len(mem_size);
          base_d  = mem_addr;
          acc_d   = mem_we ? mem_wdata : '0;
        end else if (if_req && !branch_interception) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          len_d   = CW'(4);
          base_d  = pc_mem;
          acc_d   = '0;
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (cnt < len) ram_addr = base + AW'(cnt);
        if (cnt != '0) acc_d = acc_q | din_lane;
        if (cnt == len) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (state == ST_FETCH) begin
            inst_available = 1'b1;
            inst_in        = acc_q | din_lane;
            pc_back        = base;
          end else begin
            mem_done  = 1'b1;
            mem_rdata = acc_q | din_lane;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
        // A branch kills an in-flight fetch, including on its completion cycle.
        if (state == ST_FETCH && branch_interception) begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          acc_d          = '0;
          inst_available = 1'b0;
          inst_in        = '0;
          pc_back        = '0;
        end
      end

      ST_STORE: begin
        if (cnt == len) begin
          mem_done = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else if (!io_stall) begin
          ram_wr   = 1'b1;
          ram_addr = base + AW'(cnt);
          ram_dout = wr_byte;
          cnt_d    = cnt + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    memcnf = {(mem_req && mem_we) || (state == ST_STORE),
              (mem_req && !mem_we) || (state == ST_LOAD)};

    // Reset silences every output in the same cycle so an aborted store writes nothing more.
    if (rst) begin
      addr_needed    = 1'b0;
      inst_available = 1'b0;
      inst_in        = '0;
      pc_back        = '0;
      mem_done       = 1'b0;
      mem_rdata      = '0;
      memcnf         = '0;
      ram_addr       = '0;
      ram_dout       = '0;
      ram_wr         = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: transaction-level randomized bench; a byte-addressed reference memory predicts
// fetch/load data, store byte sequences and completion latencies.
module tb_mem_ctrl;

  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_mem = '0;
  logic        if_req = 1'b0;
  logic        addr_needed;
  logic        inst_available;
  logic [31:0] inst_in;
  logic [31:0] pc_back;
  logic        branch_interception = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [1:0]  memcnf;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = '0;
  logic        io_buffer_full = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] dev_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .pc_mem(pc_mem), .if_req(if_req), .addr_needed(addr_needed),
    .inst_available(inst_available), .inst_in(inst_in), .pc_back(pc_back),
    .branch_interception(branch_interception), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .memcnf(memcnf), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .ram_din(ram_din), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return (a[7:0] * 8'd37) + a[15:8] + 8'h11;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // RAM device: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    ram_din <= dev_rd(ram_addr);
    if (ram_wr) dev_mem[ram_addr] = ram_dout;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // One request from acceptance to completion. full_n: cycles A+1..A+full_n with the IO buffer
  // full; brk_at / rst_at: cycle (relative to A) carrying a branch / reset, or -1.
  task automatic txn(input int kind, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, input int full_n, input int brk_at, input int rst_at);
    int nb, stall, nw, exp_nw, lim;
    bit done, aborted;
    logic [31:0] exp_rd, sh;
    nb = (kind == K_FETCH) ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef IO_STALL_EN
    stall = (kind == K_STORE && a >= 32'h0003_0000) ? full_n : 0;
`else
    stall = 0;
`endif
    aborted = (kind == K_FETCH && brk_at >= 0) || (rst_at >= 0);
    exp_rd = '0;
    for (int k = 0; k < nb; k++) exp_rd = exp_rd | (32'(ref_rd(a + 32'(k))) << (8 * k));
    exp_nw = (kind != K_STORE) ? 0 : (rst_at < 0) ? nb : rst_at - 1 - stall;
    if (exp_nw < 0) exp_nw = 0;
    if (exp_nw > nb) exp_nw = nb;
    nw = 0;
    done = 1'b0;
    lim = nb + stall + 4;

    @(posedge clk); #1;
    io_buffer_full = 1'b0;
    branch_interception = 1'b0;
    if (kind == K_FETCH) begin
      if_req = 1'b1;
      pc_mem = a;
    end else begin
      mem_req = 1'b1;
      mem_we = (kind == K_STORE);
      mem_size = sz;
      mem_addr = a;
      mem_wdata = wd;
    end

    for (int n = 0; n <= lim; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        io_buffer_full = (n <= full_n);
        branch_interception = (n == brk_at);
        if (n == brk_at && kind == K_FETCH) if_req = 1'b0;
        if (rst_at >= 0) begin
          rst = (n == rst_at) || (n == rst_at + 1);
          if (n == rst_at + 1) begin
            mem_req = 1'b0;
            if_req = 1'b0;
          end
        end
      end
      @(negedge clk);
      if (n == 0) begin
        chk("addr_needed_a", 64'(addr_needed), 64'(kind == K_FETCH));
        chk("memcnf_a", 64'(memcnf), (kind == K_LOAD) ? 64'd1 : (kind == K_STORE) ? 64'd2 : 64'd0);
      end
      if (rst_at >= 0 && (n == rst_at || n == rst_at + 1))
        chk("rst_outputs", {addr_needed, inst_available, mem_done, memcnf, ram_wr, ram_addr, ram_dout}, '0);
      if (rst_at >= 0 && n == rst_at + 2) chk("idle_after_rst", 64'(addr_needed), 64'd1);
      if (kind == K_FETCH && brk_at >= 0 && n == brk_at + 1)
        chk("idle_after_branch", 64'(addr_needed), 64'd1);
      if (ram_wr) begin
        sh = wd >> (8 * nw);
        chk("write", {16'(n), ram_addr, ram_dout}, {16'(nw + 1 + stall), a + 32'(nw), sh[7:0]});
        nw++;
      end
      if ((kind == K_FETCH) ? mem_done : inst_available) chk("wrong_pulse", 64'd1, 64'd0);
      if ((kind == K_FETCH) ? inst_available : mem_done) begin
        if (aborted) chk("aborted_done", 64'd1, 64'd0);
        else begin
          chk("latency", 64'(n), 64'(nb + 1 + stall));
          if (kind == K_FETCH) chk("fetch_data", {pc_back, inst_in}, {a, exp_rd});
          else if (kind == K_LOAD) chk("load_data", 64'(mem_rdata), 64'(exp_rd));
          done = 1'b1;
          break;
        end
      end
    end
    if (!aborted && !done) chk("timeout", 64'd0, 64'd1);

    @(posedge clk); #1;
    if_req = 1'b0;
    mem_req = 1'b0;
    rst = 1'b0;
    branch_interception = 1'b0;
    io_buffer_full = 1'b0;
    chk("write_count", 64'(nw), 64'(exp_nw));
    for (int k = 0; k < exp_nw; k++) begin
      sh = wd >> (8 * k);
      ref_mem[a + 32'(k)] = sh[7:0];
    end
  endtask

  task automatic same_edge_test();
    int got_d, got_i;
    logic [31:0] exp_i;
    exp_i = {ref_rd(32'h0B), ref_rd(32'h0A), ref_rd(32'h09), ref_rd(32'h08)};
    got_d = -1;
    got_i = -1;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h100;
    if_req = 1'b1; pc_mem = 32'h8;
    for (int n = 0; n < 20 && got_i < 0; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (got_d >= 0) mem_req = 1'b0;
      end
      @(negedge clk);
      if (n <= 2) chk("se_addr_needed", 64'(addr_needed), 64'd0);
      if (mem_done) begin
        chk("se_load_latency", 64'(n), 64'd2);
        chk("se_load_data", 64'(mem_rdata), 64'h0000_00FF);
        got_d = n;
      end
      if (inst_available) begin
        chk("se_fetch_latency", 64'(n), 64'd8);
        chk("se_fetch_data", {pc_back, inst_in}, {32'h8, exp_i});
        got_i = n;
      end
    end
    if (got_d < 0) chk("se_load_timeout", 64'd0, 64'd1);
    if (got_i < 0) chk("se_fetch_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  initial begin
    int kind, brk, fulln;
    logic [31:0] a;

    preload(32'h4, 8'h13);
    preload(32'h5, 8'h05);
    preload(32'h6, 8'h00);
    preload(32'h7, 8'h00);
    preload(32'h100, 8'hFF);

    // Requests held during reset must not leak onto any output.
    rst = 1'b1; mem_req = 1'b1; mem_we = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {addr_needed, inst_available, mem_done, memcnf, ram_wr, ram_addr, ram_dout}, '0);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("idle_addr_needed", 64'(addr_needed), 64'd1);

    txn(K_FETCH, 32'h4, 2'd0, 32'h0, 0, -1, -1);
    chk("known_inst", {ref_rd(32'h7), ref_rd(32'h6), ref_rd(32'h5), ref_rd(32'h4)}, 64'h0000_0513);
    same_edge_test();
    txn(K_STORE, 32'h200, 2'd2, 32'hDEAD_BEEF, 0, -1, -1);
    txn(K_LOAD, 32'h200, 2'd2, 32'h0, 0, -1, -1);
    txn(K_LOAD, 32'h201, 2'd1, 32'h0, 0, -1, -1);
    txn(K_FETCH, 32'h10, 2'd0, 32'h0, 0, 2, -1);
    txn(K_FETCH, 32'h10, 2'd0, 32'h0, 0, -1, -1);
    txn(K_STORE, 32'h0003_0000, 2'd0, 32'h41, 3, -1, -1);
    txn(K_LOAD, 32'h0003_0000, 2'd0, 32'h0, 0, -1, -1);
    txn(K_STORE, 32'h400, 2'd2, 32'h1234_5678, 0, -1, 2);
    txn(K_LOAD, 32'h400, 2'd2, 32'h0, 0, -1, -1);
    txn(K_STORE, 32'hFFFF_FFFE, 2'd2, 32'hCAFE_F00D, 0, -1, -1);
    txn(K_FETCH, 32'hFFFF_FFFE, 2'd0, 32'h0, 0, -1, -1);

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
        : ($urandom_range(0, 9) == 0) ? 32'h0003_0000 + 32'($urandom_range(0, 7))
        : 32'($urandom_range(0, 63));
      brk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1;
      fulln = int'($urandom_range(0, 3));
      txn(kind, a, 2'($urandom_range(0, 2)), $urandom, fulln, brk, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
